// File: rtl/seg7_display_arbiter_if.sv
// Request/grant bundle between display requesters and the seg7 arbiter.
// master drives requests and data; slave (the arbiter) drives grant and display.
interface seg7_display_arbiter_if;
    logic [3:0]   req;
    logic [3:0]   urgent;
    logic [127:0] data_in;
    logic [3:0]   gnt;
    logic [31:0]  data_out;
    logic         disp_blank;
    logic         rel;

    modport master (
        output req, urgent, data_in,
        input  gnt, data_out, disp_blank, rel
    );

    modport slave (
        input  req, urgent, data_in,
        output gnt, data_out, disp_blank, rel
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seg7 display among 4 requesters.
// Optional blink of the granted display is enabled by SEG7_ARB_BLINK_EN.
module seg7_display_arbiter #(
    parameter int DWELL_CYC = 50_000_000,
    parameter int BLINK_CYC = 12_500_000
) (
    input logic clk,
    input logic rst,
    seg7_display_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_HOLD
    } state_t;

    localparam logic [25:0] DWELL_LAST = 26'(DWELL_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_gnt;
    logic [3:0]  w_gnt_nxt;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_nxt;
    logic [25:0] r_cnt;
    logic [25:0] w_cnt_nxt;
    logic [31:0] r_data;
    logic        r_rel;
    logic        w_rel_nxt;
    logic        r_blank;
    logic        w_blank_nxt;
    logic        w_new_gnt;
    logic        w_cur_req;
    logic [3:0]  w_others;
    logic [1:0]  w_pick_any;
    logic [1:0]  w_pick_oth;
    logic        w_expired;

    // First requester with its bit set, searching upward from p+1 mod 4.
    function automatic logic [1:0] f_rr(input logic [3:0] m,
                                        input logic [1:0] p);
        logic [1:0] k;
        logic       found;
        f_rr  = p;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            k = p + 2'(i);
            if (!found && m[k]) begin
                f_rr  = k;
                found = 1'b1;
            end
        end
    endfunction

    assign w_cur_req  = |(bus.req & r_gnt);
    assign w_others   = bus.req & ~r_gnt;
    assign w_pick_any = f_rr(bus.req, r_ptr);
    assign w_pick_oth = f_rr(w_others, r_ptr);
    assign w_expired  = (r_cnt == DWELL_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = 1'b0;
        w_new_gnt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = S_DWELL;
                    w_gnt_nxt   = 4'b0001 << w_pick_any;
                    w_ptr_nxt   = w_pick_any;
                    w_cnt_nxt   = '0;
                    w_new_gnt   = 1'b1;
                end
            end
            S_DWELL, S_HOLD: begin
                // A dropped request wins over dwell expiry.
                if (!w_cur_req) begin
                    w_rel_nxt = 1'b1;
                    w_cnt_nxt = '0;
                    if (|w_others) begin
                        w_state_nxt = S_DWELL;
                        w_gnt_nxt   = 4'b0001 << w_pick_oth;
                        w_ptr_nxt   = w_pick_oth;
                        w_new_gnt   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (|w_others &&
                             (r_state == S_HOLD || w_expired)) begin
                    w_rel_nxt   = 1'b1;
                    w_state_nxt = S_DWELL;
                    w_gnt_nxt   = 4'b0001 << w_pick_oth;
                    w_ptr_nxt   = w_pick_oth;
                    w_cnt_nxt   = '0;
                    w_new_gnt   = 1'b1;
                end else if (r_state == S_DWELL && w_expired) begin
                    w_state_nxt = S_HOLD;
                end else if (r_state == S_DWELL && r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 26'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

`ifdef SEG7_ARB_BLINK_EN
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    logic [BW-1:0] r_bcnt;
    logic [BW-1:0] w_bcnt_nxt;
    logic          r_phase;
    logic          w_phase_nxt;
    logic          w_urg;

    assign w_urg = |(bus.urgent & r_gnt);

    // Each new grant restarts the blink visible.
    always_comb begin
        w_bcnt_nxt  = '0;
        w_phase_nxt = 1'b0;
        w_blank_nxt = 1'b0;
        if (w_state_nxt == S_IDLE) begin
            w_blank_nxt = 1'b1;
        end else if (!w_new_gnt && w_urg) begin
            if (r_bcnt == BLINK_LAST) begin
                w_phase_nxt = ~r_phase;
            end else begin
                w_phase_nxt = r_phase;
                w_bcnt_nxt  = r_bcnt + 1'b1;
            end
            w_blank_nxt = w_phase_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_bcnt  <= w_bcnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end
`else
    logic w_unused_urgent;

    assign w_unused_urgent = ^bus.urgent;

    always_comb begin
        w_blank_nxt = (w_state_nxt == S_IDLE);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_data  <= '0;
            r_rel   <= 1'b0;
            r_blank <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rel   <= w_rel_nxt;
            r_blank <= w_blank_nxt;
            if (|w_gnt_nxt) begin
                r_data <= bus.data_in[32*w_ptr_nxt +: 32];
            end else begin
                r_data <= '0;
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.data_out   = r_data;
    assign bus.disp_blank = r_blank;
    assign bus.rel        = r_rel;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scoreboard bench for seg7_display_arbiter (DWELL_CYC=4, BLINK_CYC=3).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_seg7_display_arbiter;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] d;
        logic        b;
        logic        r;
        int          id;
    } exp_t;

`ifdef SEG7_ARB_BLINK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] dv [4];
    exp_t        sbq [$];
    exp_t        me;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          step_n  = 0;
    bit          pat [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    seg7_display_arbiter_if bus ();

    seg7_display_arbiter #(
        .DWELL_CYC(4),
        .BLINK_CYC(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            n_tests++;
            if (bus.gnt !== me.g || bus.data_out !== me.d ||
                bus.disp_blank !== me.b || bus.rel !== me.r ||
                !$onehot0(bus.gnt)) begin
                n_fail++;
                $display("FAIL step%0d: got gnt=%b data=%h blank=%b rel=%b, want gnt=%b data=%h blank=%b rel=%b",
                         me.id, bus.gnt, bus.data_out, bus.disp_blank,
                         bus.rel, me.g, me.d, me.b, me.r);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] ug, input logic [3:0] eg,
                        input logic eb, input logic erel);
        exp_t e;
        rst         = r;
        bus.req     = rq;
        bus.urgent  = ug;
        bus.data_in = {dv[3], dv[2], dv[1], dv[0]};
        @(posedge clk);
        #1;
        e.g  = eg;
        e.b  = eb;
        e.r  = erel;
        e.d  = '0;
        for (int i = 0; i < 4; i++) if (eg[i]) e.d = dv[i];
        e.id = step_n;
        step_n++;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.urgent  = '0;
        dv[0]       = 32'h0000_1234;
        dv[1]       = 32'hBBBB_0001;
        dv[2]       = 32'hCCCC_0002;
        dv[3]       = 32'hDDDD_0003;
        bus.data_in = {dv[3], dv[2], dv[1], dv[0]};
        do_reset();
        do_reset();

        // single requester: grant, dwell, hold, data tracking, release
        repeat (5) step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
        dv[0] = 32'h0000_5678;
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
        dv[0] = 32'h0000_1234;
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // two requesters alternate every 4 cycles
        do_reset();
        for (int k = 1; k <= 12; k++)
            step(1'b0, 4'b0011, 4'b0000,
                 (((k - 1) / 4) % 2 == 1) ? 4'b0010 : 4'b0001,
                 1'b0, (k > 1) && ((k - 1) % 4 == 0));

        // drop all, then lone requester holds, then preempted from HOLD
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        repeat (10) step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b0, 1'b1);

        // early drop mid-dwell hands straight to next pending requester
        step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1);
        step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1);
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

        // drop on the expiry cycle goes idle rather than HOLD
        do_reset();
        repeat (4) step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);

        // reset mid-dwell, then all request
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
        repeat (4) step(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b1);

        // blink of the granted display
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b0, 4'b0001, 4'b0001, 4'b0001, BL ? pat[i] : 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
        repeat (4) step(1'b0, 4'b0001, 4'b1110, 4'b0001, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_display_arbiter.md
SEG7_DISPLAY_ARBITER -- requirements
Module: seg7_display_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL_CYC, default 50_000_000, giving the minimum grant hold in clk cycles (1 s at 50 MHz).
REQ-002 The block SHALL have parameter BLINK_CYC, default 12_500_000, giving the blink half-period in clk cycles.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  4  per-requester display request; the requester holds it high while it wants the display.
REQ-006 urgent  input  4  per-requester blink request; it is only used when blink is compiled in.
REQ-007 data_in  input  128  packed BCD data; requester i uses data_in[32*i+31:32*i].
REQ-008 gnt  output  4  one-hot grant; all zeros when idle.
REQ-009 data_out  output  32  data for the 8-digit scanned seg7 driver.
REQ-010 disp_blank  output  1  1 means the display must be dark.
REQ-011 rel  output  1  one-cycle pulse on the cycle after any grant is withdrawn or moved.

Function
REQ-012 The FSM SHALL have three states: IDLE (no grant), DWELL (grant held, dwell counter running) and HOLD (dwell expired, grant kept).
REQ-013 From IDLE, if any req is sampled high at edge N, the block SHALL assert gnt and load data_out at edge N+1 (1-cycle latency) and enter DWELL.
REQ-014 Winner selection SHALL be round-robin: search starts at last_gnt+1 mod 4 and takes the first requester with req high.
REQ-015 In DWELL and HOLD, data_out SHALL track the granted requester's data_in every cycle (registered, 1-cycle delay).
REQ-016 In DWELL, the dwell counter SHALL count 0..DWELL_CYC-1; it is 26 bits wide and saturates with no wrap.
REQ-017 At count DWELL_CYC-1, if another requester is pending, the grant SHALL move to the next requester per round-robin on the next edge, reloading the counter and staying in DWELL.
REQ-018 At count DWELL_CYC-1 with no other requester pending, the FSM SHALL enter HOLD and keep the grant.
REQ-019 In HOLD, any other req high SHALL move the grant to the next requester per round-robin on the next edge, and the FSM SHALL enter DWELL.
REQ-020 If the granted req drops in any state, the grant SHALL be withdrawn on the next edge, with no minimum dwell.
REQ-021 After such a withdrawal, if others are pending the next requester per round-robin SHALL be granted on that same edge with no idle gap; otherwise the FSM SHALL go to IDLE.
REQ-022 When the granted req drops in the same cycle the dwell expires, the drop rule (REQ-020/021) SHALL take precedence.
REQ-023 rel SHALL pulse for one cycle on every grant withdrawal or move; it SHALL NOT pulse on the initial grant from IDLE.
REQ-024 In IDLE, disp_blank SHALL be 1 and data_out SHALL hold 0.
REQ-025 While a grant is active, disp_blank SHALL be 0 unless overridden by blink (REQ-029).
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 While rst is high at a clk edge, the block SHALL set: gnt=0, data_out=0, disp_blank=1, rel=0, state=IDLE, counters=0, and the round-robin pointer=3 so that requester 0 wins first.
REQ-028 A reset asserted mid-DWELL or mid-HOLD SHALL drop the grant on that edge without pulsing rel.

Configuration
REQ-029 With macro SEG7_ARB_BLINK_EN defined: while the granted requester's urgent bit is 1, disp_blank SHALL toggle every BLINK_CYC cycles.
REQ-030 With SEG7_ARB_BLINK_EN defined, blink phase SHALL start visible (0) on every new grant, and disp_blank SHALL return to 0 within 1 cycle of urgent falling.
REQ-031 Without SEG7_ARB_BLINK_EN: urgent SHALL be ignored, no blink counter SHALL be synthesized, and disp_blank SHALL equal (state==IDLE).

Verification (DWELL_CYC=4, BLINK_CYC=3)
REQ-032 Reset, then req=0001 with data0=0x00001234 -> gnt=0001 and data_out=0x00001234 one cycle later, disp_blank=0, rel=0.
REQ-033 req=0011 from IDLE -> gnt=0001 for 4 cycles, then gnt=0010 with a rel pulse; with both held, grants alternate every 4 cycles.
REQ-034 req=0100 alone for 10 cycles -> gnt=0100 throughout (HOLD); raising req[0] -> gnt=0001 on the next edge.
REQ-035 With gnt=0010 at dwell count 1, drop req[1] while req[3] is high -> gnt=1000 on the next edge and rel=1 for one cycle; drop all -> gnt=0000, disp_blank=1, data_out=0.
REQ-036 Assert rst mid-DWELL with gnt=0100 -> all outputs at reset values on that edge; after release, req=1111 -> gnt=0001.
REQ-037 With SEG7_ARB_BLINK_EN defined, granted urgent=1 -> disp_blank sequence 0,0,0,1,1,1,0...; without the macro, disp_blank stays 0.
